ui_add_pipe: RTL and testbench

UI_ADD_PIPE -- requirements
Module: ui_add_pipe

---
 rtl/ui_add_pipe.sv | 121 ++++++++++++
 tb/tb_ui_add_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ui_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ui_add_pipe
// Description : Pipelined unsigned N-bit adder. The carry chain is cut into
//               STAGES chunks of N/STAGES bits, one chunk per stage, with a
//               valid/ready handshake and a global stall. Optional
//               saturation to all-ones on carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_add_pipe #(
    parameter int N      = 64,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] c,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int W = N / STAGES;

    // Per-stage pipeline state. Stage k holds sum chunks 0..k, the carry out
    // of chunk k, and the operands still needed by the stages after it.
    logic [N-1:0] opa_q   [STAGES];
    logic [N-1:0] opb_q   [STAGES];
    logic [N-1:0] sum_q   [STAGES];
    logic         carry_q [STAGES];
    logic         valid_q [STAGES];

    logic [N-1:0] opa_d   [STAGES];
    logic [N-1:0] opb_d   [STAGES];
    logic [N-1:0] sum_d   [STAGES];
    logic         carry_d [STAGES];
    logic         valid_d [STAGES];

    // Inputs seen by each stage: index 0 is the port side, index k+1 is the
    // output of stage k. Keeps every stage uniform with no special case.
    logic [N-1:0] src_a   [STAGES+1];
    logic [N-1:0] src_b   [STAGES+1];
    logic [N-1:0] src_sum [STAGES+1];
    logic         src_cy  [STAGES+1];
    logic         src_vld [STAGES+1];

    logic [W:0]   w_chunk;
    logic         w_adv;

    // The whole pipe moves together; it only stalls when the output slot is
    // occupied and not being consumed.
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = valid_q[STAGES-1];
    assign c         = sum_q[STAGES-1];
    assign ovf       = carry_q[STAGES-1];

    // Route the port inputs and each stage's registered outputs to the next stage.
    always_comb begin
        src_a[0]   = a;
        src_b[0]   = b;
        src_sum[0] = '0;
        src_cy[0]  = 1'b0;
        src_vld[0] = in_valid;
        for (int k = 0; k < STAGES; k++) begin
            src_a[k+1]   = opa_q[k];
            src_b[k+1]   = opb_q[k];
            src_sum[k+1] = sum_q[k];
            src_cy[k+1]  = carry_q[k];
            src_vld[k+1] = valid_q[k];
        end
    end

    // Each stage adds its own chunk plus the carry from the previous stage and
    // merges the chunk into the partial sum travelling down the pipe.
    always_comb begin
        w_chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_chunk = {1'b0, src_a[k][k*W +: W]}
                    + {1'b0, src_b[k][k*W +: W]}
                    + {{W{1'b0}}, src_cy[k]};
            opa_d[k]            = src_a[k];
            opb_d[k]            = src_b[k];
            sum_d[k]            = src_sum[k];
            sum_d[k][k*W +: W]  = w_chunk[W-1:0];
            carry_d[k]          = w_chunk[W];
            valid_d[k]          = src_vld[k];
        end
        // Saturation is folded into the last stage so c stays a plain flop output.
        if ((SAT != 0) && carry_d[STAGES-1]) begin
            sum_d[STAGES-1] = {N{1'b1}};
        end
    end

    // Pipeline registers: clear on reset, shift on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k]   <= opa_d[k];
                opb_q[k]   <= opb_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ui_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ui_add_pipe
// Description : Self-checking bench for ui_add_pipe (N=64, STAGES=4) with a
//               wrap-around instance and a saturating instance sharing stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ui_add_pipe;

    localparam int N      = 64;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;

    wire          in_ready, ovf, out_valid;
    wire  [N-1:0] c;
    wire          in_ready_s, ovf_s, out_valid_s;
    wire  [N-1:0] c_s;

    ui_add_pipe #(.N(N), .STAGES(STAGES), .SAT(0)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready), .c(c), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    ui_add_pipe #(.N(N), .STAGES(STAGES), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready_s), .c(c_s), .ovf(ovf_s), .out_valid(out_valid_s),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] op_a;
        logic [N-1:0] op_b;
        int           cyc;
        bit           lat;
    } item_t;

    item_t        exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    bit           lat_chk = 1'b0;
    bit           prev_stall = 1'b0;
    logic [N-1:0] prev_c = '0;
    bit           rnd_done = 1'b0;
    int           stale_cnt = 0;

    task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on acceptance, pop and compare on consumption.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                check("stall_in_ready", {63'b0, in_ready}, '0);
                if (prev_stall) check("stall_c_stable", c, prev_c);
                prev_stall = 1'b1;
                prev_c     = c;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 64'd1, 64'd0);
                end else begin
                    item_t        it;
                    logic [N:0]   s;
                    it = exp_q.pop_front();
                    s  = {1'b0, it.op_a} + {1'b0, it.op_b};
                    check("c", c, s[N-1:0]);
                    check("ovf", {63'b0, ovf}, {63'b0, s[N]});
                    check("sat_valid", {63'b0, out_valid_s}, 64'd1);
                    check("c_sat", c_s, s[N] ? {N{1'b1}} : s[N-1:0]);
                    check("ovf_sat", {63'b0, ovf_s}, {63'b0, s[N]});
                    if (it.lat) check("latency", 64'(cyc - it.cyc), 64'(STAGES));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{op_a: a, op_b: b, cyc: cyc, lat: lat_chk});
            end
        end
    end

    // Present one pair and hold it until accepted; leaves in_valid high so
    // consecutive calls form a back-to-back burst.
    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y);
        int n = 0;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a pair presented: it must not be accepted.
        rst = 1'b1; in_valid = 1'b1; a = 64'd9; b = 64'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, '0);
        check("rst_c", c, '0);
        check("rst_ovf", {63'b0, ovf}, '0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'b0, out_valid}, '0);
        @(posedge clk); #1;

        // Basic, chunk carries, overflow, all with exact latency.
        lat_chk = 1'b1;
        send(64'd5, 64'd7);
        in_valid = 1'b0;
        drain();
        send(64'h0000_0000_0000_FFFF, 64'd1);
        send(64'h0000_FFFF_FFFF_FFFF, 64'd1);
        send(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001);
        in_valid = 1'b0;
        drain();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid = 1'b0;
        drain();

        // Throughput: 10 back-to-back pairs (i, 2i).
        for (int i = 1; i <= 10; i++) send(64'(i), 64'(2 * i));
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure: hold out_ready low for 5 cycles once the first result shows.
        fork
            begin
                for (int i = 0; i < 6; i++) send({$urandom, $urandom}, {$urandom, $urandom});
                in_valid = 1'b0;
            end
            begin
                int n = 0;
                out_ready = 1'b0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_first_valid", {63'b0, out_valid}, 64'd1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pairs in flight.
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 64'(i + 100));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {63'b0, out_valid}, '0);
        check("mid_rst_c", c, '0);
        check("mid_rst_ovf", {63'b0, ovf}, '0);
        stale_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale_cnt++;
        end
        check("no_stale_result", 64'(stale_cnt), 64'd0);
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Random traffic with random gaps and random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    if (i % 5 == 0) send({N{1'b1}} - 64'($urandom_range(0, 3)), 64'($urandom_range(0, 5)));
                    else            send({$urandom, $urandom}, {$urandom, $urandom});
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
